ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/npc_pkg.sv | 19 +
 rtl/ifu_fetch_if.sv | 28 ++
 rtl/ifu_pc.sv | 38 +++
 rtl/ifu_fetch.sv | 95 +++++++++
 tb/tb_ifu_fetch.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the fetch front end: reset pc, nop encoding and
// the fetch FSM state encoding.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are forced to 0.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// Handshakes: a transfer happens on a posedge where valid and ready are both 1;
// once valid is raised its payload stays stable until that transfer or a redirect.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_pc.sv
// Program counter register with its next-pc mux: reset, redirect, +4, hold.
module ifu_pc
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Redirect beats the sequential advance; the +4 wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: request, wait for the word, hold it
// for decode; redirects squash whatever is in flight.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  ifu_fetch_if.master      bus,
  output fetch_state_t     dbg_state
);

  fetch_state_t state_d, state_q;
  logic         drop_d, drop_q;
  logic [31:0]  out_inst_d, out_inst_q;
  logic [31:0]  out_pc_d, out_pc_q;
  logic [31:0]  pc;
  logic         advance;
  logic         req_fire;

  ifu_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .advance        (advance),
    .pc             (pc)
  );

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
    advance    = 1'b0;
    case (state_q)
      S_REQ: begin
        // A request issued alongside a redirect fetches the old pc: mark it stale.
        if (req_fire) begin
          state_d = S_WAIT;
          drop_d  = drop_q || bus.redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          drop_d = 1'b0;
          if (bus.redirect_valid || drop_q) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_HOLD;
            out_inst_d = bus.imem_resp_data;
            out_pc_d   = pc;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          state_d = S_REQ;
        end else if (bus.out_ready) begin
          state_d = S_REQ;
          advance = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // A reset while a request is outstanding leaves its response to be discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      drop_q     <= (state_q == S_WAIT);
      out_inst_q <= NOP_INST;
      out_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = (state_q == S_HOLD);
  assign bus.out_inst       = out_inst_q;
  assign bus.out_pc         = out_pc_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, zero-wait fetch, decode stall,
// redirects in every state, pc wrap and reset during an outstanding request.
module tb_ifu_fetch;

  logic clk;
  logic rst;
  npc_pkg::fetch_state_t dbg_state;
  int vectors;
  int miscompares;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    settle();
    vectors++;
    if (bus.imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_valid got %0b want 0", bus.imem_req_valid);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.out_inst !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL reset_out_inst got %h want 00000013", bus.out_inst);
    end
    vectors++;
    if (bus.out_pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL reset_out_pc got %h want 80000000", bus.out_pc);
    end
    vectors++;
    if (dbg_state !== npc_pkg::S_REQ) begin
      miscompares++;
      $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    rst = 1'b0;
    settle();
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL first_req got v=%0b a=%h want v=1 a=80000000",
               bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  // Cycle 1 accepts, cycle 2 responds, cycle 3 offers to decode.
  task automatic test_zero_wait();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0010_0093;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_cycle got ov=%0b rv=%0b want 0 0", bus.out_valid, bus.imem_req_valid);
    end
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0010_0093 || bus.out_pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL zero_wait_out got v=%0b i=%h p=%h want 1 00100093 80000000",
               bus.out_valid, bus.out_inst, bus.out_pc);
    end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0010_0093 ||
          bus.out_pc !== 32'h8000_0000 || bus.imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_%0d got v=%0b i=%h p=%h rv=%0b want 1 00100093 80000000 0",
                 i, bus.out_valid, bus.out_inst, bus.out_pc, bus.imem_req_valid);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    settle();
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_accept got rv=%0b a=%h ov=%0b want 1 80000004 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.out_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0103;
    tick();
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL redirect_wait got ov=%0b rv=%0b a=%h want 0 1 80000100",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_redirect_hold();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0020_0113;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0020_0113 || bus.out_pc !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL hold_out got v=%0b i=%h p=%h want 1 00200113 80000100",
               bus.out_valid, bus.out_inst, bus.out_pc);
    end
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL redirect_hold got ov=%0b rv=%0b a=%h want 0 1 80000200",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  // Redirect racing the request handshake, then redirect racing the response.
  task automatic test_redirect_races();
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0300;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h1111_1111;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0300) begin
      miscompares++;
      $display("FAIL redirect_req got ov=%0b rv=%0b a=%h want 0 1 80000300",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h2222_2222;
    bus.redirect_valid  = 1'b1;
    bus.redirect_pc     = 32'h8000_0400;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0400) begin
      miscompares++;
      $display("FAIL redirect_resp got ov=%0b rv=%0b a=%h want 0 1 80000400",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_req got rv=%0b a=%h want 1 fffffffc", bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h1234_5678;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFFC || bus.out_inst !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL wrap_out got v=%0b p=%h i=%h want 1 fffffffc 12345678",
               bus.out_valid, bus.out_pc, bus.out_inst);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    settle();
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_next got rv=%0b a=%h want 1 00000000", bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hBAD0_BAD0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL rst_wait_req got ov=%0b rv=%0b a=%h want 0 1 80000000",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_req_ready  = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hBAD1_BAD1;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL rst_wait_drop got ov=%0b rv=%0b a=%h want 0 1 80000000",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0030_0193;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0030_0193 || bus.out_pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL rst_wait_refetch got v=%0b i=%h p=%h want 1 00300193 80000000",
               bus.out_valid, bus.out_inst, bus.out_pc);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_zero_wait();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_races();
    test_wrap();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
